led_flow_ctrl: RTL and testbench
================================

Name: led_flow_ctrl

Overview:
Running-light (LED water-flow) sequencer that sits directly downstream of the periodic tick counter. It consumes the counter's one-cycle tick pulse and advances an LED pattern on each qualifying tick. A small mode FSM selects the pattern. A mode key pulse (already debounced upstream) cycles through the modes.

Parameters:
LED_W, 4, number of LEDs driven; legal range >= 2.
TICK_DIV, 1, input ticks per pattern step; legal range >= 1. An elaboration-time check rejects 0.

Ports:
sys_clk  input  1  system clock
sys_rst  input  1  asynchronous reset, active-high
tick_in  input  1  one-cycle strobe from the upstream counter
mode_key  input  1  one-cycle pulse; advance to the next mode
pause  input  1  level; while high, the pattern and prescaler are frozen
led_out  output  LED_W  LED drive pattern (registered)
mode_out  output  2  current mode (registered)
step_done  output  1  one-cycle pulse; high in the same cycle led_out changes due to a step

Behaviour:
- Reset (asynchronous, takes effect immediately, no clock edge needed):
  - led_out = {0..01}
  - mode_out = LEFT (0)
  - direction = up
  - prescaler = 0
  - step_done = 0
- Modes, cycled by mode_key: LEFT(0) -> RIGHT(1) -> BOUNCE(2) -> BLINK(3) -> LEFT.
- Seed pattern per mode, loaded on entry:
  - LEFT = {0..01}
  - RIGHT = {10..0}
  - BOUNCE = {0..01} with direction = up
  - BLINK = all zeros
- Mode change:
  - On mode_key: at the next edge, mode_out advances, led_out loads the new mode's seed, and the prescaler clears.
  - step_done stays 0 in that cycle.
- Step qualification:
  - A qualifying tick is tick_in=1 and pause=0 and mode_key=0.
  - The prescaler counts qualifying ticks from 0 to TICK_DIV-1.
  - A step occurs on the qualifying tick where prescaler == TICK_DIV-1; the prescaler then wraps to 0.
  - With TICK_DIV=1, every qualifying tick is a step.
- Latency: led_out and step_done update on the clock edge that samples the stepping tick (one cycle after tick_in is presented). step_done is high for exactly that one cycle.
- Step rules:
  - LEFT: rotate left; the MSB wraps to the LSB.
  - RIGHT: rotate right; the LSB wraps to the MSB.
  - BOUNCE: shift in the current direction. The next step after reaching the MSB moves down; the next step after reaching the LSB moves up. The end LEDs are never repeated.
  - BLINK: led_out = ~led_out.
- Pause:
  - Ticks are ignored and the prescaler holds.
  - mode_key is still honoured.
- Simultaneous mode_key and tick_in: mode_key wins and the tick is discarded.
- Simultaneous tick_in and pause: the tick is discarded.
- mode_key held for multiple cycles: advances once per cycle it is high. Callers must supply pulses.
- Pattern invariant: outside BLINK, exactly one bit of led_out is set at all times.

Optional Feature:
LED_FLOW_ACTIVE_LOW_EN:
- Defined: led_out is driven as the bitwise inverse of the internal pattern, for boards with active-low LEDs. The reset output value becomes {1..10}. mode_out and step_done are unaffected.
- Undefined: led_out equals the internal pattern, active-high.

Decomposition:
- Package led_flow_pkg holds:
  - mode encodings LEFT/RIGHT/BOUNCE/BLINK as 2-bit localparams
  - the mode count constant
  - seed-pattern functions parameterised by width
- Natural sub-module: tick_prescaler. It contains the TICK_DIV counter with pause and clear inputs, and emits a step strobe.
- The FSM and pattern register stay in led_flow_ctrl.

Test Plan:
Unless a line says otherwise, LED_W=4, TICK_DIV=1, and the macro is undefined.
1. Release reset, apply 5 isolated ticks in LEFT -> led_out 0010, 0100, 1000, 0001, 0010; step_done is a 1-cycle pulse after each tick.
2. One mode_key pulse, then 3 ticks -> mode_out=1, led_out=1000 the next cycle, then 0100, 0010, 0001.
3. Select BOUNCE, apply 7 ticks -> 0010, 0100, 1000, 0100, 0010, 0001, 0010.
4. mode_key and tick_in in the same cycle while in LEFT with pattern 0100 -> mode_out=1, led_out=1000, step_done stays 0.
5. TICK_DIV=3, pause high across the 2nd tick of 4 ticks -> exactly one step, on the 4th tick.
6. Assert sys_rst asynchronously mid-BLINK with led_out=1111 -> led_out=0001 and mode_out=0 immediately, with no clock edge; the first tick after release gives 0010.

Source files
------------

// File: rtl/led_flow_pkg.sv
// led_flow_pkg: mode encodings and seed patterns shared by the LED flow sequencer
package led_flow_pkg;

    localparam int          SEED_MAX_W  = 64;
    localparam int          MODE_CNT    = 4;
    localparam logic [1:0]  MODE_LEFT   = 2'd0;
    localparam logic [1:0]  MODE_RIGHT  = 2'd1;
    localparam logic [1:0]  MODE_BOUNCE = 2'd2;
    localparam logic [1:0]  MODE_BLINK  = 2'd3;

    // Seed loaded on entry to a mode, right-aligned in a wide word; callers truncate to their width.
    function automatic logic [SEED_MAX_W-1:0] seed_pattern(input logic [1:0] mode, input int w);
        logic [SEED_MAX_W-1:0] s;
        s = '0;
        if (mode == MODE_RIGHT)
            s[w-1] = 1'b1;
        else if (mode != MODE_BLINK)
            s[0] = 1'b1;
        return s;
    endfunction

endpackage

// File: rtl/led_flow_ctrl_tick_prescaler.sv
// led_flow_ctrl_tick_prescaler: divides qualifying ticks by DIV and emits one step strobe per DIV ticks
module led_flow_ctrl_tick_prescaler #(
    parameter int DIV = 1
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic tick,
    input  logic pause,
    input  logic clr,
    output logic step
);

    localparam int          CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;
    logic          qual;

    generate
        if (DIV < 1) begin : g_bad_div
            $error("led_flow_ctrl_tick_prescaler: DIV must be >= 1");
        end
    endgenerate

    // A tick only counts when not paused and not displaced by a mode change.
    always_comb begin
        qual = tick & ~pause & ~clr;
        step = qual & (cnt == LAST);
    end

    // Counter clears on mode change, holds while paused, and wraps on the stepping tick.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (qual)
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end

endmodule

// File: rtl/led_flow_ctrl.sv
// led_flow_ctrl: running-light sequencer with LEFT/RIGHT/BOUNCE/BLINK modes (option: LED_FLOW_ACTIVE_LOW_EN inverts led_out)
module led_flow_ctrl
    import led_flow_pkg::*;
#(
    parameter int LED_W    = 4,
    parameter int TICK_DIV = 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             tick_in,
    input  logic             mode_key,
    input  logic             pause,
    output logic [LED_W-1:0] led_out,
    output logic [1:0]       mode_out,
    output logic             step_done
);

    logic [1:0]       mode, mode_nxt;
    logic [LED_W-1:0] pat, pat_nxt;
    logic             dir_up, dir_up_nxt;
    logic             step;

    generate
        if (TICK_DIV < 1) begin : g_bad_div
            $error("led_flow_ctrl: TICK_DIV must be >= 1");
        end
        if (LED_W < 2) begin : g_bad_w
            $error("led_flow_ctrl: LED_W must be >= 2");
        end
    endgenerate

    led_flow_ctrl_tick_prescaler #(
        .DIV(TICK_DIV)
    ) u_prescaler (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .tick    (tick_in),
        .pause   (pause),
        .clr     (mode_key),
        .step    (step)
    );

    // Mode, pattern, direction and step strobe registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            mode      <= MODE_LEFT;
            pat       <= LED_W'(seed_pattern(MODE_LEFT, LED_W));
            dir_up    <= 1'b1;
            step_done <= 1'b0;
        end else begin
            mode      <= mode_nxt;
            pat       <= pat_nxt;
            dir_up    <= dir_up_nxt;
            step_done <= step;
        end
    end

    // Next mode and pattern: a mode key loads the next mode's seed and discards any tick.
    always_comb begin
        mode_nxt   = mode_key ? mode + 2'd1 : mode;
        pat_nxt    = pat;
        dir_up_nxt = dir_up;
        if (mode_key) begin
            pat_nxt    = LED_W'(seed_pattern(mode_nxt, LED_W));
            dir_up_nxt = 1'b1;
        end else if (step) begin
            case (mode)
                MODE_LEFT:   pat_nxt = {pat[LED_W-2:0], pat[LED_W-1]};
                MODE_RIGHT:  pat_nxt = {pat[0], pat[LED_W-1:1]};
                MODE_BOUNCE: begin
                    pat_nxt    = dir_up ? pat << 1 : pat >> 1;
                    dir_up_nxt = pat_nxt[LED_W-1] ? 1'b0 : pat_nxt[0] ? 1'b1 : dir_up;
                end
                default:     pat_nxt = ~pat;
            endcase
        end
    end

    // Drive outputs from the registered state, inverting the LEDs for active-low boards.
    always_comb begin
        mode_out = mode;
`ifdef LED_FLOW_ACTIVE_LOW_EN
        led_out  = ~pat;
`else
        led_out  = pat;
`endif
    end

endmodule

// File: tb/tb_led_flow_ctrl.sv
// tb_led_flow_ctrl: directed checks of the LED flow sequencer at TICK_DIV=1 and TICK_DIV=3
module tb_led_flow_ctrl;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       tick_in = 1'b0, mode_key = 1'b0, pause = 1'b0;
    logic       tick3 = 1'b0, key3 = 1'b0, pause3 = 1'b0;
    logic [3:0] led_out, led3;
    logic [1:0] mode_out, mode3;
    logic       step_done, step3;
    int         errors = 0;
    int         checks = 0;

    always #5 sys_clk = ~sys_clk;

    led_flow_ctrl #(.LED_W(4), .TICK_DIV(1)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .tick_in   (tick_in),
        .mode_key  (mode_key),
        .pause     (pause),
        .led_out   (led_out),
        .mode_out  (mode_out),
        .step_done (step_done)
    );

    led_flow_ctrl #(.LED_W(4), .TICK_DIV(3)) dut3 (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .tick_in   (tick3),
        .mode_key  (key3),
        .pause     (pause3),
        .led_out   (led3),
        .mode_out  (mode3),
        .step_done (step3)
    );

    function automatic logic [3:0] lv(input logic [3:0] p);
`ifdef LED_FLOW_ACTIVE_LOW_EN
        return ~p;
`else
        return p;
`endif
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic t, input logic k, input logic p);
        tick_in  = t;
        mode_key = k;
        pause    = p;
        @(posedge sys_clk);
        #1;
        tick_in  = 1'b0;
        mode_key = 1'b0;
        pause    = 1'b0;
    endtask

    task automatic cyc3(input logic t, input logic p);
        tick3  = t;
        pause3 = p;
        @(posedge sys_clk);
        #1;
        tick3  = 1'b0;
        pause3 = 1'b0;
    endtask

    initial begin
        logic [3:0] t1 [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        logic [3:0] t2 [3] = '{4'b0100, 4'b0010, 4'b0001};
        logic [3:0] t3 [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_led", 8'(led_out), 8'(lv(4'b0001)));
        chk("rst_mode", 8'(mode_out), 8'd0);
        chk("rst_step", 8'(step_done), 8'd0);
        sys_rst = 1'b0;
        cyc(0, 0, 0);
        chk("idle_led", 8'(led_out), 8'(lv(4'b0001)));
        // LEFT rotation with isolated ticks
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0);
            chk("left_led", 8'(led_out), 8'(lv(t1[i])));
            chk("left_step", 8'(step_done), 8'd1);
            cyc(0, 0, 0);
            chk("left_step_off", 8'(step_done), 8'd0);
        end
        // RIGHT
        cyc(0, 1, 0);
        chk("right_mode", 8'(mode_out), 8'd1);
        chk("right_seed", 8'(led_out), 8'(lv(4'b1000)));
        chk("right_key_step", 8'(step_done), 8'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0);
            chk("right_led", 8'(led_out), 8'(lv(t2[i])));
            cyc(0, 0, 0);
        end
        // BOUNCE
        cyc(0, 1, 0);
        chk("bounce_mode", 8'(mode_out), 8'd2);
        chk("bounce_seed", 8'(led_out), 8'(lv(4'b0001)));
        for (int i = 0; i < 7; i++) begin
            cyc(1, 0, 0);
            chk("bounce_led", 8'(led_out), 8'(lv(t3[i])));
            cyc(0, 0, 0);
        end
        // tick with pause is discarded
        cyc(1, 0, 1);
        chk("pause_led", 8'(led_out), 8'(lv(4'b0010)));
        chk("pause_step", 8'(step_done), 8'd0);
        // mode_key honoured while paused -> BLINK
        cyc(0, 1, 1);
        chk("blink_mode", 8'(mode_out), 8'd3);
        chk("blink_seed", 8'(led_out), 8'(lv(4'b0000)));
        cyc(1, 0, 0);
        chk("blink_led", 8'(led_out), 8'(lv(4'b1111)));
        // asynchronous reset mid-cycle
        #2;
        sys_rst = 1'b1;
        #1;
        chk("async_rst_led", 8'(led_out), 8'(lv(4'b0001)));
        chk("async_rst_mode", 8'(mode_out), 8'd0);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        cyc(1, 0, 0);
        chk("post_rst_led", 8'(led_out), 8'(lv(4'b0010)));
        cyc(1, 0, 0);
        chk("pre_collide_led", 8'(led_out), 8'(lv(4'b0100)));
        // mode_key wins over simultaneous tick
        cyc(1, 1, 0);
        chk("collide_mode", 8'(mode_out), 8'd1);
        chk("collide_led", 8'(led_out), 8'(lv(4'b1000)));
        chk("collide_step", 8'(step_done), 8'd0);
        // TICK_DIV=3 with pause over the 2nd tick
        cyc3(1, 0);
        chk("div3_t1", 8'({step3, led3}), 8'({1'b0, lv(4'b0001)}));
        cyc3(0, 0);
        cyc3(1, 1);
        chk("div3_t2", 8'({step3, led3}), 8'({1'b0, lv(4'b0001)}));
        cyc3(0, 0);
        cyc3(1, 0);
        chk("div3_t3", 8'({step3, led3}), 8'({1'b0, lv(4'b0001)}));
        cyc3(0, 0);
        cyc3(1, 0);
        chk("div3_t4", 8'({step3, led3}), 8'({1'b1, lv(4'b0010)}));
        cyc3(0, 0);
        chk("div3_off", 8'(step3), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
